// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: NUM_M masters share one slave, with the
// grant locked for a whole CYC and a per-strobe ACK watchdog that returns ERR.
module wb_rr_arbiter #(
  parameter int NUM_M   = 4,
  parameter int AW      = 2,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_M-1:0]    m_cyc_i,
  input  logic [NUM_M-1:0]    m_stb_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*AW-1:0] m_adr_i,
  input  logic [NUM_M*DW-1:0] m_dat_i,
  output logic [DW-1:0]       m_dat_o,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic [NUM_M-1:0]    m_err_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_adr_o,
  output logic [DW-1:0]       s_dat_o,
  input  logic [DW-1:0]       s_dat_i,
  input  logic                s_ack_i,
  output logic [NUM_M-1:0]    gnt_o,
  output logic                timeout_o
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_q;
  logic [IW-1:0]    g_q;
  logic [IW-1:0]    last_q;
  logic [NUM_M-1:0] gnt_q;

  logic             own;
  logic             cyc_raw;
  logic             stb_raw;
  logic             expire;
  logic             found;
  logic [IW-1:0]    pick;
  int               idx;

  assign own     = (state_q == OWN);
  assign cyc_raw = own & m_cyc_i[g_q];
  assign stb_raw = cyc_raw & m_stb_i[g_q];

  // Rotating search starting just above the last owner.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx   = 0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = (int'(last_q) + k) % NUM_M;
      if (!found && m_cyc_i[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= IW'(NUM_M - 1);
      gnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= OWN;
            g_q     <= pick;
            last_q  <= pick;
            gnt_q   <= {{(NUM_M-1){1'b0}}, 1'b1} << pick;
          end
        end
        OWN: begin
          // last_q already holds g, so an expired owner drops to lowest priority.
          if (!m_cyc_i[g_q] || expire) begin
            state_q <= IDLE;
            gnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // A same-cycle ACK always beats expiry.
      assign expire = stb_raw & ~s_ack_i & (cnt_q == CW'(TIMEOUT - 1));

      always_comb begin
        cnt_d = '0;
        if (stb_raw && !s_ack_i && !expire) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
      end
    end else begin : g_nowd
      assign expire = 1'b0;
    end
  endgenerate

  assign s_cyc_o   = cyc_raw & ~expire;
  assign s_stb_o   = stb_raw & ~expire;
  assign s_we_o    = own & m_we_i[g_q];
  assign s_adr_o   = own ? m_adr_i[int'(g_q)*AW +: AW] : '0;
  assign s_dat_o   = own ? m_dat_i[int'(g_q)*DW +: DW] : '0;
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = gnt_q & {NUM_M{s_ack_i & s_stb_o}};
  assign m_err_o   = gnt_q & {NUM_M{expire}};
  assign timeout_o = expire;
  assign gnt_o     = gnt_q;

endmodule
